// File: rtl/program_loader.sv
// Boot loader: takes a length / payload / checksum byte frame, writes the payload
// into instruction memory and releases the CPU only when the checksum matches.
module program_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00
) (
  input  logic              clk,
  input  logic              initialize,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_w_en,
  output logic [ADDR_W-1:0] imem_w_addr,
  output logic [7:0]        imem_w_data,
  output logic              cpu_hold,
  output logic              startup,
  output logic              load_error,
  output logic [7:0]        byte_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CSUM    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } state_t;

  // Running checksum is a plain modulo-256 byte sum.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t            state_r, state_next_s;
  logic [7:0]        len_r, len_next_s;
  logic [7:0]        sum_r, sum_next_s;
  logic [7:0]        count_r, count_next_s;
  logic              err_r, err_next_s;
  logic              hold_r, hold_next_s;
  logic              wen_r, wen_next_s;
  logic [ADDR_W-1:0] waddr_r, waddr_next_s;
  logic [7:0]        wdata_r, wdata_next_s;
  logic              startup_r, startup_next_s;
  logic              ready_state_s;
  logic              accept_s;

  // Ready is decoded from state, and a reload request blocks acceptance in the same cycle.
  assign ready_state_s = (state_r == ST_IDLE) || (state_r == ST_LOAD) || (state_r == ST_CSUM);
  assign in_ready      = ready_state_s & ~reload;
  assign accept_s      = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk or posedge initialize) begin
    if (initialize) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and datapath next-value logic.
  always_comb begin
    state_next_s = state_r;
    len_next_s   = len_r;
    sum_next_s   = sum_r;
    count_next_s = count_r;
    err_next_s   = err_r;
    hold_next_s  = hold_r;
    wen_next_s   = 1'b0;
    waddr_next_s = waddr_r;
    wdata_next_s = wdata_r;

    if (reload) begin
      state_next_s = ST_IDLE;
      hold_next_s  = 1'b1;
      count_next_s = 8'd0;
      err_next_s   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (in_data != 8'd0) begin
              len_next_s   = in_data;
              sum_next_s   = 8'd0;
              count_next_s = 8'd0;
              err_next_s   = 1'b0;
              state_next_s = ST_LOAD;
            end else begin
              err_next_s = 1'b1;
            end
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            // Address wraps naturally in ADDR_W bits.
            wen_next_s   = 1'b1;
            waddr_next_s = BASE_ADDR + ADDR_W'(count_r);
            wdata_next_s = in_data;
            sum_next_s   = csum_add(sum_r, in_data);
            count_next_s = count_r + 8'd1;
            if ((count_r + 8'd1) == len_r) begin
              state_next_s = ST_CSUM;
            end else begin
              state_next_s = ST_LOAD;
            end
          end else begin
            state_next_s = ST_LOAD;
          end
        end
        ST_CSUM: begin
          if (accept_s) begin
            if (in_data == sum_r) begin
              state_next_s = ST_RELEASE;
            end else begin
              err_next_s   = 1'b1;
              state_next_s = ST_IDLE;
            end
          end else begin
            state_next_s = ST_CSUM;
          end
        end
        ST_RELEASE: begin
          hold_next_s  = 1'b0;
          state_next_s = ST_RUN;
        end
        ST_RUN: begin
          state_next_s = ST_RUN;
        end
        default: begin
          state_next_s = ST_IDLE;
          hold_next_s  = 1'b1;
        end
      endcase
    end

    startup_next_s = (state_next_s == ST_RELEASE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge initialize) begin
    if (initialize) begin
      len_r     <= 8'd0;
      sum_r     <= 8'd0;
      count_r   <= 8'd0;
      err_r     <= 1'b0;
      hold_r    <= 1'b1;
      wen_r     <= 1'b0;
      waddr_r   <= BASE_ADDR;
      wdata_r   <= 8'd0;
      startup_r <= 1'b0;
    end else begin
      len_r     <= len_next_s;
      sum_r     <= sum_next_s;
      count_r   <= count_next_s;
      err_r     <= err_next_s;
      hold_r    <= hold_next_s;
      wen_r     <= wen_next_s;
      waddr_r   <= waddr_next_s;
      wdata_r   <= wdata_next_s;
      startup_r <= startup_next_s;
    end
  end

  assign imem_w_en   = wen_r;
  assign imem_w_addr = waddr_r;
  assign imem_w_data = wdata_r;
  assign cpu_hold    = hold_r;
  assign startup     = startup_r;
  assign load_error  = err_r;
  assign byte_count  = count_r;

endmodule
